ifu_litebpu: RTL and testbench

- Lite static branch-prediction unit in the IFU, directly downstream of the mini-decoder.
- Consumes the decoded branch/jump info for the instruction in the IFU IR and produces the predicted-taken flag plus the two next-PC adder operands.
- Resolves jalr base registers: x0 is constant, x1 comes from a dedicated RF port, xN uses the shared rs1 read port. Asserts a wait that stalls fetch until the operand is safe.

---
 rtl/ifu_litebpu_pkg.sv | 15 +
 rtl/ifu_litebpu.sv | 141 ++++++++++++++
 tb/tb_ifu_litebpu.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_litebpu_pkg.sv
// Shared IFU constants for the lite branch-prediction unit: FSM encodings and
// sequential next-PC increments.
package ifu_litebpu_pkg;

    typedef logic [1:0] bpu_state_t;

    localparam bpu_state_t BPU_ST_IDLE     = 2'd0;
    localparam bpu_state_t BPU_ST_WAIT_DEP = 2'd1;
    localparam bpu_state_t BPU_ST_RD_RS1   = 2'd2;
    localparam bpu_state_t BPU_ST_HOLD     = 2'd3;

    localparam int unsigned BPU_INC_RV32 = 4;
    localparam int unsigned BPU_INC_RV16 = 2;

endpackage

// File: rtl/ifu_litebpu.sv
// Static branch predictor: backward branches and all jumps predicted taken;
// resolves the jalr base register through x0 / dedicated x1 / shared rs1 port.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no jalr xN in progress; may claim the rs1 port immediately
// WAIT_DEP | jalr xN blocked by a pending writer or a busy rs1 port
// RD_RS1   | rs1 read issued last cycle; read data drives op1 this cycle
// HOLD     | prediction presented but not accepted; op1 from rs1_q
module ifu_litebpu
    import ifu_litebpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    input  logic [PC_SIZE-1:0] pc,
    input  logic               dec_valid,
    input  logic               dec_rv32,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [XLEN-1:0]    dec_bjp_imm,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
    input  logic               bpu_accept,
    input  logic               x1_dep,
    input  logic               xn_dep,
    input  logic               ir_rs1en,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    output logic               bpu2rf_rs1_ena,
    output logic               bpu_wait,
    output logic               prdt_taken,
    output logic [PC_SIZE-1:0] prdt_pc_add_op1,
    output logic [PC_SIZE-1:0] prdt_pc_add_op2
);

    bpu_state_t      state;
    bpu_state_t      state_nxt;
    logic [XLEN-1:0] rs1_q;

    logic jalr_v;
    logic jalr_x0;
    logic jalr_x1;
    logic jalr_xn;
    logic rs1_free;

    assign jalr_v   = dec_valid & dec_jalr;
    assign jalr_x0  = jalr_v & (dec_jalr_rs1idx == RFIDX_W'(0));
    assign jalr_x1  = jalr_v & (dec_jalr_rs1idx == RFIDX_W'(1));
    assign jalr_xn  = jalr_v & ~jalr_x0 & ~jalr_x1;
    assign rs1_free = ~xn_dep & ~ir_rs1en;

    // Leaving the jalr xN (dec_valid drop or a new instruction) always returns to IDLE.
    always_comb begin
        state_nxt      = state;
        bpu2rf_rs1_ena = 1'b0;
        case (state)
            BPU_ST_IDLE: begin
                if (jalr_xn) begin
                    if (xn_dep) begin
                        state_nxt = BPU_ST_WAIT_DEP;
                    end else if (!ir_rs1en) begin
                        bpu2rf_rs1_ena = 1'b1;
                        state_nxt      = BPU_ST_RD_RS1;
                    end
                end
            end
            BPU_ST_WAIT_DEP: begin
                if (!jalr_xn) begin
                    state_nxt = BPU_ST_IDLE;
                end else if (rs1_free) begin
                    bpu2rf_rs1_ena = 1'b1;
                    state_nxt      = BPU_ST_RD_RS1;
                end
            end
            BPU_ST_RD_RS1: begin
                state_nxt = (!jalr_xn || bpu_accept) ? BPU_ST_IDLE : BPU_ST_HOLD;
            end
            BPU_ST_HOLD: begin
                if (!jalr_xn || bpu_accept) begin
                    state_nxt = BPU_ST_IDLE;
                end
            end
            default: state_nxt = BPU_ST_IDLE;
        endcase
        if (flush_req) begin
            state_nxt      = BPU_ST_IDLE;
            bpu2rf_rs1_ena = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BPU_ST_IDLE;
            rs1_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == BPU_ST_RD_RS1) begin
                rs1_q <= rf2bpu_rs1;
            end
        end
    end

    assign prdt_taken = dec_valid & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));

    assign bpu_wait = (jalr_x1 & x1_dep)
                    | (jalr_xn & ((state == BPU_ST_IDLE) | (state == BPU_ST_WAIT_DEP)));

    always_comb begin
        prdt_pc_add_op1 = '0;
        if (dec_valid) begin
            if (dec_jalr) begin
                if (jalr_x1) begin
                    prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
                end else if (jalr_xn && state == BPU_ST_RD_RS1) begin
                    prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
                end else if (jalr_xn && state == BPU_ST_HOLD) begin
                    prdt_pc_add_op1 = PC_SIZE'(rs1_q);
                end
            end else begin
                prdt_pc_add_op1 = pc;
            end
        end
    end

    always_comb begin
        prdt_pc_add_op2 = '0;
        if (dec_valid) begin
            if (dec_jalr || prdt_taken) begin
                prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);
            end else begin
                prdt_pc_add_op2 = dec_rv32 ? PC_SIZE'(BPU_INC_RV32) : PC_SIZE'(BPU_INC_RV16);
            end
        end
    end

endmodule

// File: tb/tb_ifu_litebpu.sv
// Scoreboard bench for ifu_litebpu: directed scenarios plus random instruction
// streams checked against a transaction-level prediction model.
module tb_ifu_litebpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_req = 1'b0;
    logic [31:0] pc = '0;
    logic        dec_valid = 1'b0;
    logic        dec_rv32 = 1'b0;
    logic        dec_jal = 1'b0;
    logic        dec_jalr = 1'b0;
    logic        dec_bxx = 1'b0;
    logic [31:0] dec_bjp_imm = '0;
    logic [4:0]  dec_jalr_rs1idx = '0;
    logic        bpu_accept = 1'b0;
    logic        x1_dep = 1'b0;
    logic        xn_dep = 1'b0;
    logic        ir_rs1en = 1'b0;
    logic [31:0] rf2bpu_x1 = '0;
    logic [31:0] rf2bpu_rs1 = '0;
    logic        bpu2rf_rs1_ena;
    logic        bpu_wait;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1;
    logic [31:0] prdt_pc_add_op2;

    always #5 clk = ~clk;

    ifu_litebpu #(.XLEN(32), .PC_SIZE(32), .RFIDX_W(5)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .pc(pc),
        .dec_valid(dec_valid), .dec_rv32(dec_rv32), .dec_jal(dec_jal),
        .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(dec_bjp_imm),
        .dec_jalr_rs1idx(dec_jalr_rs1idx), .bpu_accept(bpu_accept),
        .x1_dep(x1_dep), .xn_dep(xn_dep), .ir_rs1en(ir_rs1en),
        .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
        .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu_wait(bpu_wait),
        .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2)
    );

    typedef struct {
        bit          r, fl, v, rv32, jal, jalr, bxx, acc, x1d, xnd, irr;
        logic [31:0] imm, pc, x1v, rs1v;
        logic [4:0]  idx;
    } stim_t;

    typedef struct {
        bit          ena, wt, tk, care;
        logic [31:0] op1, op2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ena_cnt = 0;

    // Model: has the base read been issued, and is a read value being held for fetch.
    bit          m_issued = 1'b0;
    bit          m_holding = 1'b0;
    logic [31:0] m_hold_val = '0;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        e = '{default: 0};
        e.care = 1'b1;
        if (!s.v) return e;
        e.tk  = s.jal | s.jalr | (s.bxx & s.imm[31]);
        e.op2 = (s.jalr | e.tk) ? s.imm : (s.rv32 ? 32'd4 : 32'd2);
        if (!s.jalr) begin
            e.op1 = s.pc;
        end else if (s.idx == 5'd0) begin
            e.op1 = 32'd0;
        end else if (s.idx == 5'd1) begin
            e.op1 = s.x1v;
            e.wt  = s.x1d;
        end else if (m_issued) begin
            e.op1 = s.rs1v;
        end else if (m_holding) begin
            e.op1 = m_hold_val;
        end else begin
            e.wt   = 1'b1;
            e.care = 1'b0;
            e.ena  = !s.xnd && !s.irr && !s.fl;
        end
        return e;
    endfunction

    task automatic model_step(input stim_t s, input exp_t e);
        bit xn;
        xn = s.v && s.jalr && (s.idx > 5'd1);
        if (s.r || s.fl || !xn) begin
            m_issued  = 1'b0;
            m_holding = 1'b0;
        end else if (m_issued) begin
            m_issued   = 1'b0;
            m_holding  = !s.acc;
            m_hold_val = s.rs1v;
        end else if (m_holding) begin
            m_holding = !s.acc;
        end else begin
            m_issued = e.ena;
        end
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        rst = s.r; flush_req = s.fl; dec_valid = s.v; dec_rv32 = s.rv32;
        dec_jal = s.jal; dec_jalr = s.jalr; dec_bxx = s.bxx; dec_bjp_imm = s.imm;
        dec_jalr_rs1idx = s.idx; pc = s.pc; bpu_accept = s.acc; x1_dep = s.x1d;
        xn_dep = s.xnd; ir_rs1en = s.irr; rf2bpu_x1 = s.x1v; rf2bpu_rs1 = s.rs1v;
        e = predict(s);
        q.push_back(e);
        model_step(s, e);
        @(posedge clk);
        #1;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (bpu2rf_rs1_ena) ena_cnt++;
        if (q.size() > 0) begin
            me = q.pop_front();
            total++;
            if (bpu2rf_rs1_ena !== me.ena || bpu_wait !== me.wt || prdt_taken !== me.tk ||
                prdt_pc_add_op2 !== me.op2 || (me.care && prdt_pc_add_op1 !== me.op1)) begin
                bad++;
                $display("FAIL outputs t=%0t act ena=%b wait=%b tk=%b op1=%h op2=%h req ena=%b wait=%b tk=%b op1=%h(care=%b) op2=%h",
                         $time, bpu2rf_rs1_ena, bpu_wait, prdt_taken, prdt_pc_add_op1, prdt_pc_add_op2,
                         me.ena, me.wt, me.tk, me.op1, me.care, me.op2);
            end
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    stim_t s, j;
    exp_t  pe;
    int    kind, sel, ena0;
    bit    done;

    initial begin
        @(posedge clk);
        #1;
        // reset, outputs idle
        s = idle_stim(); s.r = 1; cyc(s); cyc(s);
        s = idle_stim(); cyc(s);

        // conditional branches: backward taken, forward not taken
        s = idle_stim(); s.v = 1; s.bxx = 1; s.rv32 = 1; s.pc = 32'h100; s.imm = 32'hFFFF_FFF0; cyc(s);
        s.imm = 32'd16; cyc(s);
        s.rv32 = 0; cyc(s);
        s = idle_stim(); s.v = 1; s.jal = 1; s.pc = 32'h400; s.imm = 32'h20; cyc(s);

        // jalr x1 blocked for three cycles
        ena0 = ena_cnt;
        j = idle_stim(); j.v = 1; j.jalr = 1; j.idx = 5'd1; j.imm = 32'h8; j.x1v = 32'h2000;
        j.x1d = 1; cyc(j); cyc(j); cyc(j);
        j.x1d = 0; j.acc = 1; cyc(j);
        s = idle_stim(); cyc(s);
        check_int("jalr_x1_no_port", ena_cnt - ena0, 0);

        // jalr x5: request, data, hold while fetch stalls
        j = idle_stim(); j.v = 1; j.jalr = 1; j.idx = 5'd5; j.imm = 32'h10; j.rv32 = 1;
        cyc(j);
        j.rs1v = 32'h3000; cyc(j);
        j.rs1v = 32'hDEAD_BEEF; cyc(j);
        j.acc = 1; cyc(j);
        s = idle_stim(); cyc(s);

        // jalr x7: two dependency cycles, one busy-port cycle
        ena0 = ena_cnt;
        j = idle_stim(); j.v = 1; j.jalr = 1; j.idx = 5'd7; j.imm = 32'h4;
        j.xnd = 1; cyc(j); cyc(j);
        j.xnd = 0; j.irr = 1; cyc(j);
        j.irr = 0; cyc(j);
        j.rs1v = 32'h5555_0000; j.acc = 1; cyc(j);
        s = idle_stim(); cyc(s);
        check_int("jalr_x7_single_ena", ena_cnt - ena0, 1);

        // flush with accept during the data cycle
        j = idle_stim(); j.v = 1; j.jalr = 1; j.idx = 5'd9; j.imm = 32'hC;
        cyc(j);
        j.fl = 1; j.acc = 1; j.rs1v = 32'h7700; cyc(j);
        s = idle_stim(); cyc(s);
        j.fl = 0; j.acc = 0; cyc(j);
        j.acc = 1; j.rs1v = 32'h7704; cyc(j);
        s = idle_stim(); cyc(s);

        // reset while waiting on a dependency
        j = idle_stim(); j.v = 1; j.jalr = 1; j.idx = 5'd7; j.xnd = 1; cyc(j);
        s = idle_stim(); s.r = 1; cyc(s);
        check_int("rs1_q_after_rst", int'(dut.rs1_q), 0);
        s = idle_stim(); cyc(s);
        j.xnd = 0; cyc(j);
        j.acc = 1; j.rs1v = 32'h0000_0A00; cyc(j);
        s = idle_stim(); cyc(s);

        // random instruction streams
        for (int t = 0; t < 300; t++) begin
            s = idle_stim();
            kind = $urandom_range(0, 3);
            s.jal = (kind == 1); s.jalr = (kind == 2); s.bxx = (kind == 3);
            s.rv32 = 1'($urandom_range(0, 1));
            s.imm = $urandom;
            if ($urandom_range(0, 1) == 1) s.imm = 32'($urandom_range(0, 4095));
            sel = $urandom_range(0, 3);
            s.idx = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : 5'($urandom_range(2, 31));
            s.pc = $urandom;
            for (int c = 0; c < 40; c++) begin
                s.v    = ($urandom_range(0, 9) != 0);
                s.x1d  = ($urandom_range(0, 2) == 0);
                s.xnd  = ($urandom_range(0, 2) == 0);
                s.irr  = ($urandom_range(0, 2) == 0);
                s.acc  = 1'($urandom_range(0, 1));
                s.fl   = ($urandom_range(0, 15) == 0);
                s.x1v  = $urandom;
                s.rs1v = $urandom;
                pe = predict(s);
                done = s.fl || (s.v && s.acc && !pe.wt);
                cyc(s);
                if (done) break;
            end
        end

        s = idle_stim(); cyc(s);
        @(negedge clk);
        #1;
        check_int("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
